// File: rtl/bus_master_ctrl_n.sv
// Bus-master control path: one register-to-register transfer per command over a
// selectable arbitrated bus, with grant timeout, grant-loss abort and error reporting.
module bus_master_ctrl_n #(
   parameter int REG_AW  = 2,
   parameter int NUM_BUS = 2,
   parameter int BSEL_W  = 3,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                mode,
   input  logic [REG_AW-1:0]   src_sel,
   input  logic [REG_AW-1:0]   dst_sel,
   input  logic [BSEL_W-1:0]   bus_sel,
   input  logic [NUM_BUS-1:0]  grant,
   output logic [NUM_BUS-1:0]  busreq,
   output logic                read_write,
   output logic                rw,
   output logic                rwA,
   output logic [REG_AW-1:0]   sr,
   output logic [REG_AW-1:0]   dr,
   output logic [REG_AW-1:0]   srA,
   output logic                dr_we,
   output logic                busy,
   output logic                done,
   output logic [1:0]          err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_RD, S_WR, S_ABORT, S_DONE
   } state_t;

   state_t              state_reg, state_next;
   logic                mode_reg;
   logic [REG_AW-1:0]   src_reg, dst_reg;
   logic [BSEL_W-1:0]   bus_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [1:0]          err_reg;

   logic [NUM_BUS-1:0]  bus_onehot;
   logic                grant_hit, bus_ok, timeout_hit;

   // One-hot view of the latched bus index; drives both busreq and grant selection.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_BUS; gi++) begin : g_onehot
         assign bus_onehot[gi] = (bus_reg == BSEL_W'(gi));
      end
   endgenerate

   assign grant_hit   = |(grant & bus_onehot);
   assign bus_ok      = (32'(bus_sel) < 32'(NUM_BUS));
   assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start && bus_ok) state_next = S_REQ;
         S_REQ: begin
            if (grant_hit)        state_next = S_RD;
            else if (timeout_hit) state_next = S_IDLE;
         end
         S_RD: begin
            if (!grant_hit)    state_next = S_ABORT;
            else if (mode_reg) state_next = S_DONE;
            else               state_next = S_WR;
         end
         S_WR:    state_next = grant_hit ? S_DONE : S_ABORT;
         S_ABORT: state_next = S_IDLE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Command latch, wait counter and sticky error code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_reg <= 1'b0;
         src_reg  <= '0;
         dst_reg  <= '0;
         bus_reg  <= '0;
         cnt_reg  <= '0;
         err_reg  <= 2'b00;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  if (bus_ok) begin
                     mode_reg <= mode;
                     src_reg  <= src_sel;
                     dst_reg  <= dst_sel;
                     bus_reg  <= bus_sel;
                     cnt_reg  <= '0;
                     err_reg  <= 2'b00;
                  end else begin
                     err_reg  <= 2'b11;
                  end
               end
            end
            S_REQ: begin
               if (!grant_hit) begin
                  if (timeout_hit)      err_reg <= 2'b01;
                  else if (cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_RD, S_WR: if (!grant_hit) err_reg <= 2'b10;
            default: ;
         endcase
      end
   end

   always_comb begin
      busreq     = '0;
      read_write = 1'b0;
      rw         = 1'b0;
      rwA        = 1'b0;
      sr         = '0;
      dr         = '0;
      srA        = '0;
      dr_we      = 1'b0;
      done       = 1'b0;
      busy       = (state_reg != S_IDLE);
      err        = err_reg;
      case (state_reg)
         S_REQ: begin
            busreq     = bus_onehot;
            read_write = 1'b1;
         end
         S_RD: begin
            busreq     = bus_onehot;
            read_write = 1'b1;
            rw         = 1'b1;
            sr         = src_reg;
            if (mode_reg) begin
               rwA = 1'b1;
               srA = src_reg;
            end
         end
         S_WR: begin
            busreq = bus_onehot;
            dr     = dst_reg;
            dr_we  = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule
